// File: rtl/oc8051_su_gate_if.sv
// Commit bus from the decode/execute stage into the supervisor gate monitor.
// Handshake: instr_valid is a one-cycle commit strobe with no ready/backpressure; opcode,
// target and pc are only meaningful in a cycle where instr_valid is high.
interface oc8051_su_gate_if;
    logic        instr_valid;
    logic [7:0]  opcode;
    logic [15:0] target;
    logic [15:0] pc;

    modport master (output instr_valid, output opcode, output target, output pc);
    modport slave  (input  instr_valid, input  opcode, input  target, input  pc);
endinterface

// File: rtl/oc8051_su_gate.sv
// Classifies committed control transfers as gate calls, supervisor returns or illegal
// entries, and keeps a shadow nesting stack so only the matching RET leaves supervisor.
module oc8051_su_gate #(
    parameter logic [15:0] GATE_BASE   = 16'hF000,
    parameter int          GATE_COUNT  = 16,
    parameter int          GATE_STRIDE = 8,
    parameter logic [15:0] SU_BASE     = 16'hE000,
    parameter int          LEVELS      = 4,
    parameter int          NEST_W      = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    oc8051_su_gate_if.slave       bus,
    input  logic                  clear_violation,
    output logic                  enter_su_mode,
    output logic                  leave_su_mode,
    output logic                  su_active,
    output logic                  gate_violation,
    output logic [15:0]           violation_pc
);

    localparam int                SP_W        = $clog2(LEVELS + 1);
    localparam logic [SP_W-1:0]   SP_MAX      = SP_W'(LEVELS);
    localparam logic [SP_W-1:0]   SP_ONE      = SP_W'(1);
    localparam logic [NEST_W-1:0] NEST_MAX    = '1;
    localparam logic [NEST_W-1:0] NEST_ONE    = NEST_W'(1);
    localparam logic [16:0]       GATE_SPAN   = 17'(GATE_COUNT * GATE_STRIDE);
    localparam logic [15:0]       STRIDE_MASK = 16'(GATE_STRIDE - 1);

    logic [SP_W-1:0]   sp_q;
    logic [NEST_W-1:0] nest_q [LEVELS];

    logic              is_call;
    logic              is_jump;
    logic              is_ret;
    logic [15:0]       gate_off;
    logic              gate_hit;
    logic              su_target;

    logic [NEST_W-1:0] top_q;
    logic [NEST_W-1:0] top_d;
    logic              top_we;
    logic              push;
    logic [SP_W-1:0]   sp_d;
    logic              enter_d;
    logic              leave_d;
    logic              viol_d;

    // Opcode classes; ACALL/AJMP carry page bits in opcode[7:5].
    assign is_call = (bus.opcode == 8'h12) || (bus.opcode[4:0] == 5'h11);
    assign is_jump = (bus.opcode == 8'h02) || (bus.opcode[4:0] == 5'h01) ||
                     (bus.opcode == 8'h80) || (bus.opcode == 8'h73);
    assign is_ret  = (bus.opcode == 8'h22) || (bus.opcode == 8'h32);

    assign gate_off  = bus.target - GATE_BASE;
    assign gate_hit  = (bus.target >= GATE_BASE) && ({1'b0, gate_off} < GATE_SPAN) &&
                       ((gate_off & STRIDE_MASK) == 16'h0000);
    assign su_target = (bus.target >= SU_BASE);

    // Top-of-stack read by compare rather than index, so sp == 0 never reads out of range.
    always_comb begin
        top_q = '0;
        for (int i = 0; i < LEVELS; i++) begin
            if (SP_W'(i + 1) == sp_q) top_q = nest_q[i];
        end
    end

    always_comb begin
        sp_d    = sp_q;
        top_d   = top_q;
        top_we  = 1'b0;
        push    = 1'b0;
        enter_d = 1'b0;
        leave_d = 1'b0;
        viol_d  = 1'b0;
        if (bus.instr_valid) begin
            if (is_call) begin
                if (gate_hit) begin
                    if (sp_q < SP_MAX) begin
                        push    = 1'b1;
                        sp_d    = sp_q + SP_ONE;
                        enter_d = 1'b1;
                    end else begin
                        viol_d = 1'b1;
                    end
                end else if (sp_q == '0) begin
                    viol_d = su_target;
                end else if (top_q == NEST_MAX) begin
                    viol_d = 1'b1;
                end else begin
                    top_we = 1'b1;
                    top_d  = top_q + NEST_ONE;
                end
            end else if (is_jump) begin
                viol_d = su_target && (sp_q == '0);
            end else if (is_ret && (sp_q != '0)) begin
                if (top_q == '0) begin
                    sp_d    = sp_q - SP_ONE;
                    leave_d = 1'b1;
                end else begin
                    top_we = 1'b1;
                    top_d  = top_q - NEST_ONE;
                end
            end
        end
    end

    // Boot runs in supervisor: one context open with an empty nest count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp_q <= SP_ONE;
            for (int i = 0; i < LEVELS; i++) nest_q[i] <= '0;
        end else begin
            sp_q <= sp_d;
            for (int i = 0; i < LEVELS; i++) begin
                if (push && (SP_W'(i) == sp_q)) begin
                    nest_q[i] <= '0;
                end else if (top_we && (SP_W'(i + 1) == sp_q)) begin
                    nest_q[i] <= top_d;
                end
            end
        end
    end

    // A new violation beats a coincident clear; the first offender's pc sticks.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            enter_su_mode  <= 1'b0;
            leave_su_mode  <= 1'b0;
            gate_violation <= 1'b0;
            violation_pc   <= 16'h0000;
        end else begin
            enter_su_mode <= enter_d;
            leave_su_mode <= leave_d;
            if (viol_d) begin
                gate_violation <= 1'b1;
                if (!gate_violation || clear_violation) violation_pc <= bus.pc;
            end else if (clear_violation) begin
                gate_violation <= 1'b0;
                violation_pc   <= 16'h0000;
            end
        end
    end

    assign su_active = (sp_q != '0);

endmodule
